// File: rtl/kitchen_timer_pkg.sv
// Shared definitions for the kitchen timer: FSM state encoding, BCD digit
// limits, nibble positions of the packed {min_tens, min_ones, sec_tens,
// sec_ones} time value, and a load-value validity check.
package kitchen_timer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StAlarm  = 2'd3
    } kt_state_e;

    // Largest legal value of a decimal digit and of the seconds-tens digit.
    localparam logic [3:0] BcdMax     = 4'd9;
    localparam logic [3:0] SecTensMax = 4'd5;

    // LSB positions of each nibble in load_value / digits.
    localparam int unsigned SecOnesLsb = 0;
    localparam int unsigned SecTensLsb = 4;
    localparam int unsigned MinOnesLsb = 8;
    localparam int unsigned MinTensLsb = 12;

    function automatic logic bcd_time_valid(input logic [15:0] v);
        return (v[SecOnesLsb +: 4] <= BcdMax)     &&
               (v[SecTensLsb +: 4] <= SecTensMax) &&
               (v[MinOnesLsb +: 4] <= BcdMax)     &&
               (v[MinTensLsb +: 4] <= BcdMax);
    endfunction

endpackage

// File: rtl/kitchen_timer_bcd_digit.sv
// bcd_digit: one mod-N BCD digit with synchronous load and enable.
//   clk, reset   : clock, asynchronous active-high reset (digit -> 0)
//   en_i         : step once this cycle (ignored when load_i is high)
//   down_i       : 0 = increment, 1 = decrement
//   load_i       : load load_val_i (takes priority over en_i)
//   load_val_i   : value to load
//   q_o          : current digit value
//   carry_o      : en_i while at the wrap boundary for the current direction
//   at_min_o     : digit is 0
//   at_max_o     : digit is N-1
module bcd_digit #(
    parameter int unsigned N = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       down_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] q_o,
    output logic       carry_o,
    output logic       at_min_o,
    output logic       at_max_o
);

    localparam logic [3:0] Max = 4'(N - 1);

    logic [3:0] q_q;
    logic [3:0] q_d;

    assign at_min_o = (q_q == 4'd0);
    assign at_max_o = (q_q == Max);
    assign carry_o  = en_i && (down_i ? at_min_o : at_max_o);
    assign q_o      = q_q;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                q_d = at_min_o ? Max : q_q - 4'd1;
            end else begin
                q_d = at_max_o ? 4'd0 : q_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/kitchen_timer_core.sv
// kitchen_timer_core: MM:SS BCD kitchen timer counting up or down once per
// TICK_DIV clock cycles, with pause/resume, load, clear and alarm.
//   clk, reset     : clock, asynchronous active-high reset
//   start_i        : begin (from IDLE) or resume (from PAUSED)
//   stop_i         : pause while running
//   clear_i        : digits -> 00:00, back to IDLE, from any state
//   mode_i         : 0 = up, 1 = down; latched on start from IDLE
//   load_i         : load load_value_i in IDLE or PAUSED
//   load_value_i   : BCD {min_tens, min_ones, sec_tens, sec_ones}
//   ack_i          : acknowledge alarm, return to IDLE
//   digits_o       : current BCD time
//   running_o      : state is RUN
//   alarm_o        : state is ALARM
//   tick_o         : one-cycle pulse in the cycle after each digits step
//   load_err_o     : one-cycle pulse after a rejected load
module kitchen_timer_core
    import kitchen_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned WRAP     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_i,
    input  logic        mode_i,
    input  logic        load_i,
    input  logic [15:0] load_value_i,
    input  logic        ack_i,
    output logic [15:0] digits_o,
    output logic        running_o,
    output logic        alarm_o,
    output logic        tick_o,
    output logic        load_err_o
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

    kt_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic        mode_q, mode_d;
    logic        tick_q, tick_d;
    logic        load_err_q, load_err_d;

    logic        step_en;
    logic        dig_load;
    logic [15:0] dig_load_val;
    logic [15:0] digits;
    logic [3:0]  dig_en;
    logic [3:0]  carry;
    logic [3:0]  at_min;
    logic [3:0]  at_max;
    logic        unused_carry;

    // Ripple enable: each digit steps when the one below it carries/borrows.
    assign dig_en       = {carry[2:0], step_en};
    assign unused_carry = carry[3];

    bcd_digit #(.N(int'(BcdMax) + 1)) u_sec_ones (
        .clk       (clk),
        .reset     (reset),
        .en_i      (dig_en[0]),
        .down_i    (mode_q),
        .load_i    (dig_load),
        .load_val_i(dig_load_val[SecOnesLsb +: 4]),
        .q_o       (digits[SecOnesLsb +: 4]),
        .carry_o   (carry[0]),
        .at_min_o  (at_min[0]),
        .at_max_o  (at_max[0])
    );

    bcd_digit #(.N(int'(SecTensMax) + 1)) u_sec_tens (
        .clk       (clk),
        .reset     (reset),
        .en_i      (dig_en[1]),
        .down_i    (mode_q),
        .load_i    (dig_load),
        .load_val_i(dig_load_val[SecTensLsb +: 4]),
        .q_o       (digits[SecTensLsb +: 4]),
        .carry_o   (carry[1]),
        .at_min_o  (at_min[1]),
        .at_max_o  (at_max[1])
    );

    bcd_digit #(.N(int'(BcdMax) + 1)) u_min_ones (
        .clk       (clk),
        .reset     (reset),
        .en_i      (dig_en[2]),
        .down_i    (mode_q),
        .load_i    (dig_load),
        .load_val_i(dig_load_val[MinOnesLsb +: 4]),
        .q_o       (digits[MinOnesLsb +: 4]),
        .carry_o   (carry[2]),
        .at_min_o  (at_min[2]),
        .at_max_o  (at_max[2])
    );

    bcd_digit #(.N(int'(BcdMax) + 1)) u_min_tens (
        .clk       (clk),
        .reset     (reset),
        .en_i      (dig_en[3]),
        .down_i    (mode_q),
        .load_i    (dig_load),
        .load_val_i(dig_load_val[MinTensLsb +: 4]),
        .q_o       (digits[MinTensLsb +: 4]),
        .carry_o   (carry[3]),
        .at_min_o  (at_min[3]),
        .at_max_o  (at_max[3])
    );

    logic is_zero;
    logic is_top;
    logic down_hits_zero;
    logic presc_last;

    assign is_zero    = &at_min;
    assign is_top     = &at_max;
    assign presc_last = (presc_q == PrescLast);
    // Current value 00:01, so a down step lands on 00:00.
    assign down_hits_zero = (digits[SecOnesLsb +: 4] == 4'd1) && (&at_min[3:1]);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        mode_d       = mode_q;
        step_en      = 1'b0;
        dig_load     = 1'b0;
        dig_load_val = digits;
        load_err_d   = 1'b0;

        if (clear_i) begin
            state_d      = StIdle;
            presc_d      = '0;
            dig_load     = 1'b1;
            dig_load_val = '0;
        end else begin
            unique case (state_q)
                StIdle, StPaused: begin
                    if (load_i) begin
                        if (bcd_time_valid(load_value_i)) begin
                            dig_load     = 1'b1;
                            dig_load_val = load_value_i;
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end else if (start_i) begin
                        if (state_q == StPaused) begin
                            state_d = StRun;
                        end else if (!(mode_i && is_zero)) begin
                            state_d = StRun;
                            mode_d  = mode_i;
                            presc_d = '0;
                        end
                    end
                end
                StRun: begin
                    if (stop_i) begin
                        state_d = StPaused;
                    end else begin
                        presc_d = presc_last ? '0 : presc_q + 1'b1;
                        if (presc_last) begin
                            if (!mode_q && is_top && (WRAP == 0)) begin
                                // Saturate: hold 99:59, no step, raise alarm.
                                state_d = StAlarm;
                            end else begin
                                step_en = 1'b1;
                                if (mode_q && down_hits_zero) begin
                                    state_d = StAlarm;
                                end
                            end
                        end
                    end
                end
                StAlarm: begin
                    if (ack_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign tick_d = step_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            mode_q     <= 1'b0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign digits_o   = digits;
    assign running_o  = (state_q == StRun);
    assign alarm_o    = (state_q == StAlarm);
    assign tick_o     = tick_q;
    assign load_err_o = load_err_q;

endmodule

// File: doc/kitchen_timer_core.md
KITCHEN_TIMER_CORE -- requirements
Module: kitchen_timer_core

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick (minimum 2).
REQ-002 Parameter WRAP, default 1; in up mode, 1 = wrap 99:59->00:00, 0 = saturate at 99:59 and alarm.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begin or resume counting.
REQ-006 stop  input  1  one-cycle pulse; pause counting.
REQ-007 clear  input  1  one-cycle pulse; digits to 00:00, state IDLE.
REQ-008 mode  input  1  0 = count up, 1 = count down; sampled only on start from IDLE.
REQ-009 load  input  1  one-cycle pulse; load load_value into digits.
REQ-010 load_value  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
REQ-011 ack  input  1  alarm acknowledge pulse.
REQ-012 digits  output  16  current BCD time, same packing as load_value.
REQ-013 running  output  1  high while state is RUN.
REQ-014 alarm  output  1  high while state is ALARM.
REQ-015 tick  output  1  registered one-cycle pulse in the cycle after each digits update.
REQ-016 load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-017 States: IDLE, RUN, PAUSED, ALARM.
REQ-018 Same-cycle input priority: clear > load > stop > start; ack is honoured only in ALARM.
REQ-019 IDLE + start -> RUN; latch mode; prescaler to 0. In down mode with digits == 00:00, start is ignored and the state stays IDLE.
REQ-020 RUN + stop -> PAUSED; prescaler holds its value.
REQ-021 PAUSED + start -> RUN; prescaler resumes from its held value; latched mode is unchanged.
REQ-022 load is accepted in IDLE and PAUSED only; it is ignored in RUN and ALARM.
REQ-023 A load is rejected if any nibble exceeds 9 or sec_tens exceeds 5. On rejection: digits unchanged, load_err pulses.
REQ-024 clear is honoured in any state: digits <= 0000, prescaler <= 0, state <= IDLE.
REQ-025 In RUN, the prescaler counts 0..TICK_DIV-1. On the edge ending a cycle with prescaler == TICK_DIV-1, the prescaler wraps to 0 and digits step by one second.
REQ-026 First step occurs exactly TICK_DIV cycles after the start pulse cycle.
REQ-027 Up step: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 9->0.
REQ-028 Down step borrows symmetrically: sec_ones 0->9, sec_tens 0->5, min_ones 0->9, min_tens 0->9.
REQ-029 Down mode: the step that produces 00:00 also moves to ALARM on the same edge; running drops and alarm rises.
REQ-030 Up mode at 99:59 with WRAP=1: step to 00:00, stay in RUN.
REQ-031 Up mode at 99:59 with WRAP=0: digits hold at 99:59; move to ALARM on that tick edge; no tick pulse.
REQ-032 ALARM + ack -> IDLE with digits unchanged. start and stop are ignored in ALARM.
REQ-033 No step, and no tick pulse, occurs in IDLE, PAUSED or ALARM.

Reset
REQ-034 Reset SHALL force state IDLE, digits 0000, prescaler 0, and running, alarm, tick and load_err all 0, immediately and independent of clk.
REQ-035 Reset asserted mid-RUN abandons the count; after release, the block waits in IDLE for start.

Structure
REQ-036 Shared package kitchen_timer_pkg holds the state encodings, the BCD limit constants (9, 5) and the load_value nibble positions.
REQ-037 One sub-module, bcd_digit, SHALL be instantiated four times: a mod-N BCD digit (N parameter) with enable, up/down select, load, carry/borrow out, and an at-min/at-max flag.
REQ-038 The prescaler width SHALL be $clog2(TICK_DIV).

Verification (TICK_DIV=4)
REQ-039 Reset; start with mode=0 -> digits=0001 at cycle 4 after start, 0010 after 40 cycles; tick high one cycle after each step.
REQ-040 Load 0003 with mode=1, then start -> 0002, 0001, 0000 at 4-cycle intervals; alarm=1 on the 0000 edge; ack -> IDLE with alarm=0.
REQ-041 Load 9959, start in up mode -> next tick gives 0000 with running=1 (WRAP=1); with WRAP=0, digits stay 9959, alarm=1 and no tick pulse.
REQ-042 Start, stop at prescaler=2, wait 20 cycles, start again -> step occurs 2 cycles after resume; load 0760 while PAUSED -> load_err pulse, digits unchanged.
REQ-043 Same-cycle stop+start while in RUN -> PAUSED; same-cycle clear+load 1234 -> 0000 in IDLE; reset mid-RUN -> 0000 immediately.
